// File: rtl/freq_meter.sv
// freq_meter: period and duty meter for a slow square wave sampled on clkin.
// Define FREQ_METER_DUTY_EN to build the high-time counter; otherwise high_time reads 0.
module freq_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clkin,
    input  logic             clr,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_OVF
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t           r_state;
    state_t           w_nextState;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [WIDTH-1:0] r_cnt;
    logic             r_pend;
    logic [WIDTH-1:0] r_pendPeriod;
    logic [WIDTH-1:0] r_period;
    logic             r_valid;
    logic             r_ovf;
    logic             r_busy;
    logic             w_rise;
    logic             w_cntMax;
    logic             w_restart;
    logic             w_count;
    logic             w_publish;
    logic             w_enterOvf;

    always_ff @(posedge clkin) begin
        if (!clr) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise   = r_s2 & ~r_s3;
    assign w_cntMax = (r_cnt == CNT_MAX);

    always_ff @(posedge clkin) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_busy  <= (w_nextState == ST_MEASURE);
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:    if (w_rise) w_nextState = ST_MEASURE;
            ST_MEASURE: if (!w_rise && w_cntMax) w_nextState = ST_OVF;
            ST_OVF:     if (w_rise) w_nextState = ST_MEASURE;
            default:    w_nextState = ST_IDLE;
        endcase
    end

    // A rise in any state restarts the count; only a rise in MEASURE closes a period.
    always_comb begin
        w_restart  = 1'b0;
        w_count    = 1'b0;
        w_publish  = 1'b0;
        w_enterOvf = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_restart = w_rise;
            end
            ST_MEASURE: begin
                w_restart  = w_rise;
                w_publish  = w_rise;
                w_count    = !w_rise && !w_cntMax;
                w_enterOvf = !w_rise && w_cntMax;
            end
            ST_OVF: begin
                w_restart = w_rise;
            end
            default: begin
                w_restart = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clkin) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (w_restart) begin
            r_cnt <= CNT_ONE;
        end else if (w_count) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Results pass through one holding stage so valid lands three edges after
    // the input is first sampled high.
    always_ff @(posedge clkin) begin
        if (!clr) begin
            r_pend       <= 1'b0;
            r_pendPeriod <= '0;
        end else begin
            r_pend <= w_publish;
            if (w_publish) begin
                r_pendPeriod <= r_cnt;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (!clr) begin
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_valid <= r_pend;
            if (r_pend) begin
                r_period <= r_pendPeriod;
                r_ovf    <= 1'b0;
            end else if (w_enterOvf) begin
                r_ovf <= 1'b1;
            end
        end
    end

`ifdef FREQ_METER_DUTY_EN
    logic [WIDTH-1:0] r_hcnt;
    logic [WIDTH-1:0] r_pendHigh;
    logic [WIDTH-1:0] r_highTime;

    always_ff @(posedge clkin) begin
        if (!clr) begin
            r_hcnt     <= '0;
            r_pendHigh <= '0;
            r_highTime <= '0;
        end else begin
            if (w_restart) begin
                r_hcnt <= CNT_ONE;
            end else if (w_count) begin
                r_hcnt <= r_hcnt + {{(WIDTH-1){1'b0}}, r_s2};
            end
            if (w_publish) begin
                r_pendHigh <= r_hcnt;
            end
            if (r_pend) begin
                r_highTime <= r_pendHigh;
            end
        end
    end

    assign high_time = r_highTime;
`else
    assign high_time = '0;
`endif

    assign period = r_period;
    assign valid  = r_valid;
    assign ovf    = r_ovf;
    assign busy   = r_busy;

endmodule
